mult_control_unit: RTL and testbench
====================================

# mult_control_unit

Control unit for the shift-add multiplier datapath: it accepts a host start request with two operands and sequences the datapath's Load_Regs/Add_Regs/Shift_Regs/Decr_P strobes from its Q0/Zero status. On termination it captures the product and returns it with a one-cycle done pulse. It sits between the host logic and the datapath top; together the two form the complete multiplier.

## Interface
- BITS, 8, operand width; product width is 2*BITS+1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  host request, sampled only when ready=1.
- Multiplicando  in  BITS  host multiplicand, captured on accepted start.
- Multiplicador  in  BITS  host multiplier, captured on accepted start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when Resultado is valid.
- error  out  1  set with done when the iteration guard trips; cleared on next accepted start.
- Resultado  out  2*BITS+1  product, held until the next done.
- DP_B  out  BITS  registered multiplicand to datapath.
- DP_Q  out  BITS  registered multiplier to datapath.
- Load_Regs, Add_Regs, Shift_Regs, Decr_P  out  1 each  datapath strobes.
- Q0  in  1  datapath multiplier LSB.
- Zero  in  1  datapath counter-is-zero flag.
- P  in  3  datapath count (observed for debug only; no control decision uses it).
- Producto  in  2*BITS+1  datapath product.

## Operation
- Moore FSM with states IDLE, LOAD, SETTLE, CHECK, ADD, SHIFT, DECR, DONE; all outputs registered or decoded from state only.
- IDLE: ready=1. start=1 -> capture operands into DP_B/DP_Q, clear error and iteration counter, go to LOAD.
- LOAD: Load_Regs=1 for exactly one cycle -> SETTLE.
- SETTLE: no strobes (datapath status settles) -> CHECK.
- CHECK: no strobes. Zero=1 -> DONE. Else guard: iteration counter == BITS -> error set, go to DONE. Else Q0=1 -> ADD, Q0=0 -> SHIFT.
- ADD: Add_Regs=1 -> SHIFT.
- SHIFT: Shift_Regs=1 -> DECR.
- DECR: Decr_P=1, iteration counter +1 -> CHECK.
- DONE: Resultado <= Producto, done=1 -> IDLE.
- At most one strobe is high in any cycle; strobes never overlap.
- Iteration counter width ceil(log2(BITS+1)); it saturates and never wraps.
- DP_B/DP_Q remain stable from capture until the next accepted start.

## Timing
- Reset (asynchronous, rst=0): state IDLE, ready=1. All other outputs 0, including done, error, Resultado, DP_B, DP_Q, and all strobes. The iteration counter is 0.
- The start-accept edge is followed by Load_Regs for one cycle, then SETTLE, then the first CHECK. The first CHECK is therefore 3 cycles after accept.
- Iteration lengths, CHECK to CHECK: Q0=1 takes 4 cycles (CHECK, ADD, SHIFT, DECR). Q0=0 takes 3 cycles (CHECK, SHIFT, DECR).
- Latency from accept to done is 4 + sum of iteration lengths. For N iterations with k ones in the sampled Q0 bits, this is 4 + 3N + k cycles.
- ready falls the cycle after accept and rises the cycle after done.
- start while ready=0 is ignored (not queued).
- start held high continuously: a new operation is accepted on the first cycle after done.
- Reset mid-operation: all strobes drop immediately. No done is issued, and the FSM returns to IDLE. Resultado is cleared to 0.
- A Zero=1 observed in any state other than CHECK has no effect.

## Test plan
- Reset then idle: rst low mid-cycle -> all outputs 0 at once and ready=1. With start=0, no strobe toggles for 20 cycles.
- Basic multiply: pair with the datapath top (BITS=8) and start with 23 × 19 -> Load_Regs for 1 cycle, correct ADD/SHIFT/DECR order per Q0, then done pulse with Resultado=437 and error=0.
- Edge operands: check each of these separately.
  - 0 × 255 gives Resultado 0 and never asserts Add_Regs.
  - 255 × 255 gives Resultado 65025 with Add_Regs on every iteration.
- Latency and exclusivity check: scoreboard per cycle. The strobes must be one-hot or zero, and cycles from accept to done must equal 4 + 3N + k.
- Guard: stub datapath holds Zero=0 -> after BITS DECR pulses, the next CHECK gives done=1 and error=1. Then start → error clears.
- Back-to-back and abort:
  - start held high for two operand pairs -> second accepted the cycle after first done, both results correct.
  - Assert rst during SHIFT -> strobes low immediately, no done; the next start completes normally.

Source files
------------

// File: rtl/mult_control_unit.sv
`timescale 1ns/1ps
// mult_control_unit
// Sequencer for the shift-add multiplier datapath. It takes a host start
// request, captures both operands, and steps the datapath through
// load/add/shift/decrement. On termination it captures the product and
// presents it with a one-cycle done pulse.
module mult_control_unit #(
  parameter int BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   Multiplicando,
  input  logic [BITS-1:0]   Multiplicador,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [2*BITS:0]   Resultado,
  output logic [BITS-1:0]   DP_B,
  output logic [BITS-1:0]   DP_Q,
  output logic              Load_Regs,
  output logic              Add_Regs,
  output logic              Shift_Regs,
  output logic              Decr_P,
  input  logic              Q0,
  input  logic              Zero,
  input  logic [2:0]        P,
  input  logic [2*BITS:0]   Producto
);

  // The iteration counter must be able to hold the value BITS itself.
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] ITER_LIMIT = CW'(BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DECR,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_iter;
  logic [BITS-1:0] r_dpB;
  logic [BITS-1:0] r_dpQ;
  logic [2*BITS:0] r_result;
  logic            r_error;
  logic            w_accept;
  logic            w_guardTrip;
  logic            w_enterDone;

  // The datapath count is only kept on the port for debug visibility;
  // folding it here makes it clear no decision depends on it.
  logic w_unused;
  assign w_unused = ^P;

  // State register; an asynchronous reset parks the sequencer in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode. Zero and Q0 are consulted only in CHECK, so status
  // glitches in any other state cannot steer the sequence.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_guardTrip = 1'b0;
    w_enterDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: w_next = S_CHECK;
      S_CHECK: begin
        if (Zero) begin
          w_enterDone = 1'b1;
          w_next      = S_DONE;
        end else if (r_iter == ITER_LIMIT) begin
          w_guardTrip = 1'b1;
          w_enterDone = 1'b1;
          w_next      = S_DONE;
        end else if (Q0) begin
          w_next = S_ADD;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = S_DECR;
      S_DECR:  w_next = S_CHECK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, bumped on each decrement, and
  // held at BITS so a stuck Zero can never wrap it back under the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter <= '0;
    end else if (w_accept) begin
      r_iter <= '0;
    end else if (r_state == S_DECR && r_iter != ITER_LIMIT) begin
      r_iter <= r_iter + CW'(1);
    end
  end

  // Operand capture; the datapath sees stable operands until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dpB <= '0;
      r_dpQ <= '0;
    end else if (w_accept) begin
      r_dpB <= Multiplicando;
      r_dpQ <= Multiplicador;
    end
  end

  // Product capture on the way into DONE, so Resultado is already valid
  // during the cycle that done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if (w_enterDone) begin
      r_result <= Producto;
    end
  end

  // Guard flag: raised alongside done when the iteration limit trips and
  // held until the host starts another multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= 1'b0;
    end else if (w_guardTrip) begin
      r_error <= 1'b1;
    end
  end

  // Status and strobes are plain state decodes, so only one strobe can
  // ever be high and all of them drop the instant reset is applied.
  assign ready      = (r_state == S_IDLE);
  assign done       = (r_state == S_DONE);
  assign Load_Regs  = (r_state == S_LOAD);
  assign Add_Regs   = (r_state == S_ADD);
  assign Shift_Regs = (r_state == S_SHIFT);
  assign Decr_P     = (r_state == S_DECR);
  assign error      = r_error;
  assign Resultado  = r_result;
  assign DP_B       = r_dpB;
  assign DP_Q       = r_dpQ;

endmodule

// File: tb/tb_mult_control_unit.sv
`timescale 1ns/1ps
// Bench for mult_control_unit. A small behavioural shift-add datapath is
// wired to the controller so whole multiplies can be run end to end, and
// it can be told to hold Zero low to exercise the iteration guard.
module tb_mult_control_unit;

  localparam int BITS = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BITS-1:0]  Multiplicando;
  logic [BITS-1:0]  Multiplicador;
  logic             ready;
  logic             done;
  logic             error;
  logic [2*BITS:0]  Resultado;
  logic [BITS-1:0]  DP_B;
  logic [BITS-1:0]  DP_Q;
  logic             Load_Regs;
  logic             Add_Regs;
  logic             Shift_Regs;
  logic             Decr_P;
  logic             Q0;
  logic             Zero;
  logic [2:0]       P;
  logic [2*BITS:0]  Producto;

  int compareCount;
  int mismatchCount;
  bit forceZeroLow;

  mult_control_unit #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Multiplicando(Multiplicando),
    .Multiplicador(Multiplicador),
    .ready        (ready),
    .done         (done),
    .error        (error),
    .Resultado    (Resultado),
    .DP_B         (DP_B),
    .DP_Q         (DP_Q),
    .Load_Regs    (Load_Regs),
    .Add_Regs     (Add_Regs),
    .Shift_Regs   (Shift_Regs),
    .Decr_P       (Decr_P),
    .Q0           (Q0),
    .Zero         (Zero),
    .P            (P),
    .Producto     (Producto)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: A holds the running upper half plus carry, Q the
  // multiplier shifting out to the right, mP the remaining iteration count.
  logic [BITS:0]   mA;
  logic [BITS-1:0] mQ;
  logic [BITS-1:0] mB;
  logic [3:0]      mP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mA <= '0;
      mQ <= '0;
      mB <= '0;
      mP <= '0;
    end else if (Load_Regs) begin
      mA <= '0;
      mQ <= DP_Q;
      mB <= DP_B;
      mP <= 4'(BITS);
    end else if (Add_Regs) begin
      mA <= mA + {1'b0, mB};
    end else if (Shift_Regs) begin
      {mA, mQ} <= {1'b0, mA, mQ[BITS-1:1]};
    end else if (Decr_P) begin
      mP <= mP - 4'd1;
    end
  end

  assign Q0       = mQ[0];
  assign Zero     = forceZeroLow ? 1'b0 : (mP == 4'd0);
  assign P        = mP[2:0];
  assign Producto = {mA, mQ};

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one multiply from a negedge. Tracks strobe overlap, strobe order,
  // which iterations added, and accept-to-done latency in cycles (the
  // accepting IDLE cycle counts as cycle 0). With hold set, start stays
  // high and the task returns at the done negedge.
  task automatic applyStimulus(input string name,
                               input logic [BITS-1:0] mc,
                               input logic [BITS-1:0] mq,
                               input bit hold,
                               input int expLat,
                               input logic [2*BITS:0] expRes,
                               input bit expErr,
                               input int expAdds,
                               input logic [7:0] expMask,
                               input int expWait);
    int waitCycles;
    int cycles;
    int loads;
    int loadCycle;
    int adds;
    int shifts;
    int decrs;
    int overlap;
    int orderErr;
    int nStrobe;
    logic [15:0] addMask;
    bit prevAdd;
    bit prevShift;
    bit finished;
    Multiplicando = mc;
    Multiplicador = mq;
    start = 1'b1;
    waitCycles = 0;
    while (!ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!ready) begin
      checkOutput({name, "_acceptTimeout"}, 0, 1);
      start = 1'b0;
      return;
    end
    if (expWait >= 0) checkOutput({name, "_acceptWait"}, waitCycles, expWait);
    cycles = 0; loads = 0; loadCycle = 0; adds = 0; shifts = 0; decrs = 0;
    overlap = 0; orderErr = 0; addMask = '0;
    prevAdd = 0; prevShift = 0; finished = 0;
    while (!finished && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        if (!hold) start = 1'b0;
        checkOutput({name, "_readyLow"}, 32'(ready), 0);
        checkOutput({name, "_errCleared"}, 32'(error), 0);
        checkOutput({name, "_dpB"}, 32'(DP_B), 32'(mc));
        checkOutput({name, "_dpQ"}, 32'(DP_Q), 32'(mq));
      end
      nStrobe = int'(Load_Regs) + int'(Add_Regs) + int'(Shift_Regs) + int'(Decr_P);
      if (nStrobe > 1) overlap++;
      if (prevAdd && !Shift_Regs) orderErr++;
      if (prevShift && !Decr_P) orderErr++;
      if (Load_Regs) begin
        loads++;
        loadCycle = cycles;
      end
      if (Shift_Regs) begin
        if (shifts < 16) addMask[shifts] = prevAdd;
        shifts++;
      end
      adds  += int'(Add_Regs);
      decrs += int'(Decr_P);
      prevAdd   = Add_Regs;
      prevShift = Shift_Regs;
      if (done) finished = 1;
    end
    if (!finished) begin
      checkOutput({name, "_doneTimeout"}, 0, 1);
      start = 1'b0;
      return;
    end
    checkOutput({name, "_latency"},   cycles, expLat);
    checkOutput({name, "_result"},    32'(Resultado), 32'(expRes));
    checkOutput({name, "_error"},     32'(error), 32'(expErr));
    checkOutput({name, "_loads"},     loads, 1);
    checkOutput({name, "_loadCycle"}, loadCycle, 1);
    checkOutput({name, "_adds"},      adds, expAdds);
    checkOutput({name, "_addMask"},   32'(addMask), 32'(expMask));
    checkOutput({name, "_decrs"},     decrs, BITS);
    checkOutput({name, "_overlap"},   overlap, 0);
    checkOutput({name, "_order"},     orderErr, 0);
  endtask

  // Directed sequence: reset, idle, multiplies, guard, back-to-back, abort.
  initial begin
    int strobeHits;
    int doneHits;
    compareCount  = 0;
    mismatchCount = 0;
    forceZeroLow  = 0;
    rst           = 1'b1;
    start         = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;

    // Asynchronous reset asserted mid-cycle must take effect at once.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_ready",  32'(ready), 1);
    checkOutput("rst_done",   32'(done), 0);
    checkOutput("rst_error",  32'(error), 0);
    checkOutput("rst_result", 32'(Resultado), 0);
    checkOutput("rst_dpB",    32'(DP_B), 0);
    checkOutput("rst_dpQ",    32'(DP_Q), 0);
    checkOutput("rst_strobes", 32'({Load_Regs, Add_Regs, Shift_Regs, Decr_P}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle with start low: nothing should move for 20 cycles.
    strobeHits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Load_Regs || Add_Regs || Shift_Regs || Decr_P || done) strobeHits++;
    end
    checkOutput("idle_strobes", strobeHits, 0);
    checkOutput("idle_ready", 32'(ready), 1);

    // 23 x 19 = 437; 19 = 0b00010011 -> 3 adds, latency 4+24+3.
    applyStimulus("mul23x19", 8'd23, 8'd19, 0, 31, 17'd437, 0, 3, 8'h13, -1);
    // Zero multiplier: no adds at all, latency 4+24.
    applyStimulus("mul255x0", 8'd255, 8'd0, 0, 28, 17'd0, 0, 0, 8'h00, -1);
    // 255 x 255 = 65025, every iteration adds, latency 4+24+8.
    applyStimulus("mul255x255", 8'd255, 8'd255, 0, 36, 17'd65025, 0, 8, 8'hFF, -1);

    // Guard: Zero held low, so after 8 decrements the next CHECK trips.
    forceZeroLow = 1;
    applyStimulus("guard", 8'd23, 8'd19, 0, 31, 17'd437, 1, 3, 8'h13, -1);
    forceZeroLow = 0;
    @(negedge clk);
    checkOutput("guard_errHeld", 32'(error), 1);
    // 6 x 7 = 42; the new start must clear error.
    applyStimulus("afterGuard", 8'd6, 8'd7, 0, 31, 17'd42, 0, 3, 8'h07, -1);

    // Back-to-back with start held: 12 x 10 = 120 then 200 x 3 = 600, the
    // second accepted in the first IDLE cycle after done.
    applyStimulus("b2bFirst", 8'd12, 8'd10, 1, 30, 17'd120, 0, 2, 8'h0A, -1);
    applyStimulus("b2bSecond", 8'd200, 8'd3, 0, 30, 17'd600, 0, 2, 8'h03, 1);

    // Abort: reset asserted during SHIFT kills the operation outright.
    @(negedge clk);
    Multiplicando = 8'd9;
    Multiplicador = 8'd11;
    start = 1'b1;
    strobeHits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (Shift_Regs) begin
        strobeHits = 1;
        break;
      end
    end
    checkOutput("abort_reachedShift", strobeHits, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_strobes", 32'({Load_Regs, Add_Regs, Shift_Regs, Decr_P}), 0);
    checkOutput("abort_done",    32'(done), 0);
    checkOutput("abort_result",  32'(Resultado), 0);
    checkOutput("abort_ready",   32'(ready), 1);
    @(negedge clk);
    rst = 1'b1;
    doneHits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneHits++;
    end
    checkOutput("abort_noDone", doneHits, 0);
    // 100 x 5 = 500; 5 = 0b101 -> 2 adds.
    applyStimulus("afterAbort", 8'd100, 8'd5, 0, 30, 17'd500, 0, 2, 8'h05, -1);

    @(negedge clk);
    checkOutput("final_readyBack", 32'(ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
